// File: rtl/turkey_pkg.sv
// Shared definitions for the turkey counter front end.
//   state_t      : FSM state encoding (also driven onto state_o for LEDs)
//   P_*          : sensor-pair constants, pair ordered {left, right}
//   next_state() : pure transition function of the direction FSM
package turkey_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    L1       = 3'd1,
    BR       = 3'd2,
    R2       = 3'd3,
    R1       = 3'd4,
    BL       = 3'd5,
    L2       = 3'd6,
    WAIT_CLR = 3'd7
  } state_t;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_L    = 2'b10;
  localparam logic [1:0] P_R    = 2'b01;
  localparam logic [1:0] P_BOTH = 2'b11;

  // Every state lists all four pairs explicitly; the one pair that is
  // neither "stay" nor a legal neighbour sends the FSM to WAIT_CLR.
  function automatic state_t next_state(input state_t s, input logic [1:0] p);
    state_t n;
    n = s;
    unique case (s)
      IDLE: unique case (p)
        P_NONE: n = IDLE;
        P_L:    n = L1;
        P_R:    n = R1;
        P_BOTH: n = WAIT_CLR;
      endcase
      L1: unique case (p)
        P_L:    n = L1;
        P_BOTH: n = BR;
        P_NONE: n = IDLE;
        P_R:    n = WAIT_CLR;
      endcase
      BR: unique case (p)
        P_BOTH: n = BR;
        P_R:    n = R2;
        P_L:    n = L1;
        P_NONE: n = WAIT_CLR;
      endcase
      R2: unique case (p)
        P_R:    n = R2;
        P_NONE: n = IDLE;
        P_BOTH: n = BR;
        P_L:    n = WAIT_CLR;
      endcase
      R1: unique case (p)
        P_R:    n = R1;
        P_BOTH: n = BL;
        P_NONE: n = IDLE;
        P_L:    n = WAIT_CLR;
      endcase
      BL: unique case (p)
        P_BOTH: n = BL;
        P_L:    n = L2;
        P_R:    n = R1;
        P_NONE: n = WAIT_CLR;
      endcase
      L2: unique case (p)
        P_L:    n = L2;
        P_NONE: n = IDLE;
        P_BOTH: n = BL;
        P_R:    n = WAIT_CLR;
      endcase
      WAIT_CLR: n = (p == P_NONE) ? IDLE : WAIT_CLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/turkey_dir_fsm_sensor_filter.sv
// Two-bit synchronizer plus shared debounce filter for the beam sensors.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : {left, right} raw sensor levels, asynchronous to clk
//   filt       : {left, right} synchronized, debounced pair
// The pair is filtered as a unit: any change on either bit restarts the
// stability count, so the FSM only ever sees a pair that held steady.
module sensor_filter
  import turkey_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] raw,
  output logic [1:0] filt
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES);
  // filt is loaded on the edge where the count steps up to DEB_CYCLES-1,
  // i.e. when the count currently stands at DEB_CYCLES-2 or beyond.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'((DEB_CYCLES >= 2) ? DEB_CYCLES - 2 : 0);

  logic [SYNC_STAGES-1:0][1:0] sync_p0;
  logic [1:0]                  cand_p1;
  logic [CNT_W-1:0]            cnt_p1;
  logic [1:0]                  sync;

  assign sync = sync_p0[SYNC_STAGES-1];

  // Synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
    end
  end

  // Debounce: candidate, stability counter, filtered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_p1 <= P_NONE;
      cnt_p1  <= '0;
      filt    <= P_NONE;
    end else if (sync != cand_p1) begin
      cand_p1 <= sync;
      cnt_p1  <= '0;
    end else begin
      if (cnt_p1 != CNT_MAX) begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
      if (cnt_p1 >= CNT_FIRE) begin
        filt <= cand_p1;
      end
    end
  end

endmodule

// File: rtl/turkey_dir_fsm.sv
// Turkey crossing direction classifier.
//   clk, rst_n         : clock, asynchronous active-low reset
//   sensor_l, sensor_r : raw beam-break inputs (1 = broken), asynchronous
//   inc                : one-cycle pulse, rightward crossing completed
//   dec                : one-cycle pulse, leftward crossing completed
//   err                : one-cycle pulse on every entry into WAIT_CLR
//   state_o            : current FSM state, for LED debug
// A rightward crossing walks IDLE-L1-BR-R2-IDLE, leftward IDLE-R1-BL-L2-IDLE.
// Backing up one step is legal; anything skipping a step parks the FSM in
// WAIT_CLR until both beams are clear.
module turkey_dir_fsm
  import turkey_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_l,
  input  logic       sensor_r,
  output logic       inc,
  output logic       dec,
  output logic       err,
  output logic [2:0] state_o
);

  logic [1:0] pair_p1;
  state_t     state;
  state_t     nxt;

  sensor_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   ({sensor_l, sensor_r}),
    .filt  (pair_p1)
  );

  assign nxt     = next_state(state, pair_p1);
  assign state_o = state;

  // Direction FSM; pulses register alongside the state change causing them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      inc   <= 1'b0;
      dec   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      inc   <= (state == R2) && (pair_p1 == P_NONE);
      dec   <= (state == L2) && (pair_p1 == P_NONE);
      err   <= (nxt == WAIT_CLR) && (state != WAIT_CLR);
    end
  end

endmodule

// File: tb/tb_turkey_dir_fsm.sv
module tb_turkey_dir_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor_l = 1'b0;
  logic       sensor_r = 1'b0;
  logic       inc, dec, err;
  logic [2:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  // monitor state
  int cyc = 0;
  int inc_n, dec_n, err_n;
  int inc_first;
  int last_drive;
  int path_code, path_len;
  logic [2:0] last_st;

  turkey_dir_fsm #(.SYNC_STAGES(2), .DEB_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sensor_l (sensor_l),
    .sensor_r (sensor_r),
    .inc      (inc),
    .dec      (dec),
    .err      (err),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // Samples 1 time unit after each rising edge; records pulse cycles and
  // the sequence of distinct states as octal digits.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_n) begin
      if (inc) begin
        if (inc_n == 0) inc_first = cyc;
        inc_n++;
      end
      if (dec) dec_n++;
      if (err) err_n++;
      if (state_o != last_st) begin
        path_code = path_code * 8 + int'(state_o);
        path_len++;
        last_st = state_o;
      end
    end
  end

  task automatic clear_mon();
    inc_n = 0; dec_n = 0; err_n = 0; inc_first = -1;
    last_st = state_o;
    path_code = int'(state_o);
    path_len = 1;
  endtask

  task automatic hold(input logic [1:0] p, input int n);
    {sensor_l, sensor_r} = p;
    last_drive = cyc;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {sensor_l, sensor_r} = 2'b00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({inc, dec, err, state_o} !== 6'b000_000) begin
      miscompares++;
      $display("FAIL reset_state: got inc/dec/err/state=%b want 000000", {inc, dec, err, state_o});
    end
    rst_n = 1'b1;
    hold(2'b00, 20);
    vectors++;
    if (state_o !== 3'd0 || inc !== 1'b0 || dec !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got state=%0d inc=%b dec=%b err=%b want 0 0 0 0",
               state_o, inc, dec, err);
    end
  endtask

  task automatic test_rightward();
    int lat;
    clear_mon();
    hold(2'b10, 20);
    hold(2'b11, 20);
    hold(2'b01, 20);
    hold(2'b00, 20);
    lat = inc_first - last_drive;
    vectors++;
    if (inc_n != 1) begin
      miscompares++;
      $display("FAIL right_inc_cycles: got %0d want 1", inc_n);
    end
    vectors++;
    if (dec_n != 0 || err_n != 0) begin
      miscompares++;
      $display("FAIL right_no_dec_err: got dec=%0d err=%0d want 0 0", dec_n, err_n);
    end
    vectors++;
    if (lat < 6 || lat > 8) begin
      miscompares++;
      $display("FAIL right_inc_latency: got %0d want 7+-1", lat);
    end
    vectors++;
    if (path_code != 'o1230 || path_len != 5) begin
      miscompares++;
      $display("FAIL right_path: got %o len %0d want 1230 len 5", path_code, path_len);
    end
  endtask

  task automatic test_leftward();
    clear_mon();
    hold(2'b01, 20);
    hold(2'b11, 20);
    hold(2'b10, 20);
    hold(2'b00, 20);
    vectors++;
    if (dec_n != 1 || inc_n != 0 || err_n != 0) begin
      miscompares++;
      $display("FAIL left_counts: got dec=%0d inc=%0d err=%0d want 1 0 0", dec_n, inc_n, err_n);
    end
    vectors++;
    if (state_o !== 3'd0) begin
      miscompares++;
      $display("FAIL left_final_state: got %0d want 0", state_o);
    end
    vectors++;
    if (path_code != 'o4560 || path_len != 5) begin
      miscompares++;
      $display("FAIL left_path: got %o len %0d want 4560 len 5", path_code, path_len);
    end
  endtask

  task automatic test_backtrack();
    clear_mon();
    hold(2'b10, 20);
    hold(2'b11, 20);
    hold(2'b10, 20);
    hold(2'b00, 20);
    vectors++;
    if (inc_n != 0 || dec_n != 0 || err_n != 0) begin
      miscompares++;
      $display("FAIL backtrack_counts: got inc=%0d dec=%0d err=%0d want 0 0 0", inc_n, dec_n, err_n);
    end
    vectors++;
    if (path_code != 'o1210 || path_len != 5) begin
      miscompares++;
      $display("FAIL backtrack_path: got %o len %0d want 1210 len 5", path_code, path_len);
    end
  endtask

  task automatic test_illegal();
    clear_mon();
    hold(2'b11, 20);
    hold(2'b01, 20);
    vectors++;
    if (state_o !== 3'd7) begin
      miscompares++;
      $display("FAIL illegal_wait_state: got %0d want 7", state_o);
    end
    hold(2'b00, 20);
    vectors++;
    if (err_n != 1 || inc_n != 0 || dec_n != 0) begin
      miscompares++;
      $display("FAIL illegal_counts: got err=%0d inc=%0d dec=%0d want 1 0 0", err_n, inc_n, dec_n);
    end
    vectors++;
    if (path_code != 'o70 || path_len != 3) begin
      miscompares++;
      $display("FAIL illegal_path: got %o len %0d want 070 len 3", path_code, path_len);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    {sensor_l, sensor_r} = 2'b10;
    repeat (2) @(negedge clk);
    hold(2'b00, 20);
    vectors++;
    if (path_len != 1 || state_o !== 3'd0) begin
      miscompares++;
      $display("FAIL glitch_state: got state=%0d changes=%0d want 0 1", state_o, path_len);
    end
    vectors++;
    if (inc_n != 0 || dec_n != 0 || err_n != 0) begin
      miscompares++;
      $display("FAIL glitch_pulses: got inc=%0d dec=%0d err=%0d want 0 0 0", inc_n, dec_n, err_n);
    end
  endtask

  task automatic test_reset_mid_crossing();
    clear_mon();
    hold(2'b10, 20);
    hold(2'b11, 20);
    vectors++;
    if (state_o !== 3'd2) begin
      miscompares++;
      $display("FAIL midreset_in_br: got %0d want 2", state_o);
    end
    #3;
    rst_n = 1'b0;
    {sensor_l, sensor_r} = 2'b01;
    #1;
    vectors++;
    if ({inc, dec, err, state_o} !== 6'b000_000) begin
      miscompares++;
      $display("FAIL midreset_async_clear: got inc/dec/err/state=%b want 000000",
               {inc, dec, err, state_o});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    hold(2'b01, 20);
    hold(2'b00, 20);
    vectors++;
    if (inc_n != 0 || dec_n != 0 || err_n != 0) begin
      miscompares++;
      $display("FAIL midreset_no_pulse: got inc=%0d dec=%0d err=%0d want 0 0 0", inc_n, dec_n, err_n);
    end
    vectors++;
    if (path_code != 'o40 || path_len != 3) begin
      miscompares++;
      $display("FAIL midreset_path: got %o len %0d want 040 len 3", path_code, path_len);
    end
  endtask

  initial begin
    clear_mon();
    @(negedge clk);
    test_reset();
    test_rightward();
    test_leftward();
    test_backtrack();
    test_illegal();
    test_glitch();
    test_reset_mid_crossing();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/turkey_dir_fsm.md
Name: turkey_dir_fsm

Overview:
- Front end of the turkey counter. Watches the two beam-break sensors, left and right, and classifies each complete crossing as rightward (increment) or leftward (decrement).
- Emits one-cycle inc/dec pulses that drive the up/down count datapath built from the ripple full-adder chain.
- Also synchronizes and debounces the raw sensor inputs, and rejects aborted or illegal sequences.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the input synchronizer; legal range ≥2.
- DEB_CYCLES, 4, consecutive clock edges a synchronized sensor pair must hold before the FSM sees it; legal range ≥1. Use 4 for simulation, ~1_000_000 on board.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- sensor_l  input  1  raw left beam, 1 = broken; asynchronous to clk.
- sensor_r  input  1  raw right beam, 1 = broken; asynchronous to clk.
- inc  output  1  one-cycle pulse: rightward crossing completed.
- dec  output  1  one-cycle pulse: leftward crossing completed.
- err  output  1  one-cycle pulse: illegal transition, entering WAIT_CLR.
- state_o  output  3  current FSM state encoding, for LED debug.

Behaviour:
- Reset (rst_n=0, takes effect immediately without a clock):
  - all synchronizer flops, candidate pair, filtered pair and debounce counter clear to 0;
  - state = IDLE; inc = dec = err = 0.
  - Release is synchronous to the next clk edge.
  - Reset mid-crossing discards the crossing; no pulse is produced.
- Synchronizer: each sensor passes through SYNC_STAGES flops, giving sync pair {l,r}.
- Debounce (one 2-bit filter shared by both sensors):
  - If sync ≠ candidate: candidate <= sync, counter <= 0.
  - Otherwise the counter increments, saturating at DEB_CYCLES.
  - filtered <= candidate on the edge where the counter reaches DEB_CYCLES−1 with sync == candidate.
  - A glitch shorter than DEB_CYCLES never reaches the FSM.
- FSM, clocked on the filtered pair P = {l,r}. States: IDLE, L1, BR, R2, R1, BL, L2, WAIT_CLR.
  - IDLE: 00 stay; 10→L1; 01→R1; 11→WAIT_CLR.
  - L1: 10 stay; 11→BR; 00→IDLE; 01→WAIT_CLR.
  - BR: 11 stay; 01→R2; 10→L1; 00→WAIT_CLR.
  - R2: 01 stay; 00→IDLE with inc; 11→BR; 10→WAIT_CLR.
  - R1: 01 stay; 11→BL; 00→IDLE; 10→WAIT_CLR.
  - BL: 11 stay; 10→L2; 01→R1; 00→WAIT_CLR.
  - L2: 10 stay; 00→IDLE with dec; 11→BL; 01→WAIT_CLR.
  - WAIT_CLR: 00→IDLE; anything else stay.
- Output pulses:
  - inc, dec and err are registered and asserted on the same edge as the state change that causes them, for exactly one cycle.
  - err asserts on every entry into WAIT_CLR, never while remaining in it.
  - inc and dec are mutually exclusive by construction.
- Latency: a pair change held stable at the pins appears as a state change SYNC_STAGES+DEB_CYCLES+1 edges later (±1 for asynchronous sampling).
- Backtracking (BR→L1, R2→BR, BL→R1, L2→BL) is legal and produces no pulse. A turkey that enters and retreats yields no count.

Decomposition:
- Shared package/header turkey_pkg holds:
  - state encodings as 3-bit localparams: IDLE=0, L1=1, BR=2, R2=3, R1=4, BL=5, L2=6, WAIT_CLR=7;
  - sensor-pair constants P_NONE=00, P_L=10, P_R=01, P_BOTH=11.
- One sub-module, sensor_filter: synchronizer plus debounce, 2-bit wide, parameterized by SYNC_STAGES and DEB_CYCLES.
- The FSM stays in turkey_dir_fsm.

Test Plan (SYNC_STAGES=2, DEB_CYCLES=4, each pair held 20 cycles):
- Full rightward crossing 00→10→11→01→00 -> exactly one inc pulse, 1 cycle wide, 7±1 edges after the final 00; dec=err=0.
- Full leftward crossing 00→01→11→10→00 -> exactly one dec pulse; state_o returns to 0.
- Backtrack 00→10→11→10→00 -> no inc, dec or err; state_o path 0,1,2,1,0.
- Illegal jump 00→11→01→00 -> one err pulse; state_o=7 until the pair is 00, then 0; no inc.
- Glitch: sensor_l high for 2 cycles during IDLE -> state_o stays 0, no pulses.
- Reset mid-crossing: assert rst_n=0 while in BR -> state_o=0 and outputs 0 immediately, without a clock; after release, 01→00 gives no inc.
